// File: rtl/decode_regfile_pkg.sv
// rtl/decode_regfile_pkg.sv - state, opcode, func and field-position constants for decode_regfile
package decode_regfile_pkg;

    localparam int NREGS_DEF  = 32;
    localparam int DATA_W_DEF = 8;
    localparam int REG_AW     = 5;

    typedef enum logic [2:0] {
        STATE_IF = 3'd0,
        STATE_ID = 3'd1,
        STATE_EX = 3'd2,
        STATE_WB = 3'd3
    } state_e;

    localparam logic [5:0] OP_ADDU  = 6'h00;
    localparam logic [5:0] OP_SUBU  = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;

    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUBU = 6'h23;

    localparam int FIELD_OPCODE_MSB = 31;
    localparam int FIELD_OPCODE_LSB = 26;
    localparam int FIELD_RS_MSB     = 25;
    localparam int FIELD_RS_LSB     = 21;
    localparam int FIELD_RT_MSB     = 20;
    localparam int FIELD_RT_LSB     = 16;
    localparam int FIELD_RD_MSB     = 15;
    localparam int FIELD_RD_LSB     = 11;
    localparam int FIELD_IMM_MSB    = 15;
    localparam int FIELD_IMM_LSB    = 0;
    localparam int FIELD_FUNC_MSB   = 5;
    localparam int FIELD_FUNC_LSB   = 0;

    // R-type (opcode 0) writes rd; every other opcode writes rt.
    function automatic logic [REG_AW-1:0] dest_sel(input logic [31:0] ins);
        if (ins[FIELD_OPCODE_MSB:FIELD_OPCODE_LSB] == OP_ADDU)
            return ins[FIELD_RD_MSB:FIELD_RD_LSB];
        return ins[FIELD_RT_MSB:FIELD_RT_LSB];
    endfunction

endpackage

// File: rtl/decode_regfile_regfile_2r1w.sv
// rtl/decode_regfile_regfile_2r1w.sv - register file, two latched read ports, one write port, r0 hardwired to zero
module regfile_2r1w
    import decode_regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_en,
    input  logic [4:0]        ra,
    input  logic [4:0]        rb,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (we && wa != 5'd0) regs[wa] <= wd;
            if (rd_en) begin
                rdata_a <= (ra == 5'd0) ? '0 : regs[ra];
                rdata_b <= (rb == 5'd0) ? '0 : regs[rb];
            end
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - instruction decode, register read/writeback and retired-instruction counter
module decode_regfile
    import decode_regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [2:0]        state,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] result,
    input  logic              instruction_invalid,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic [15:0]       imm,
    output logic [DATA_W-1:0] rsv,
    output logic [DATA_W-1:0] rtv,
    output logic [4:0]        dest,
    output logic [7:0]        retired,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic in_id;
    logic wb_commit;

    assign in_id     = (state == STATE_ID);
    assign wb_commit = (state == STATE_WB) && !instruction_invalid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            opcode  <= '0;
            func    <= '0;
            imm     <= '0;
            dest    <= '0;
            retired <= '0;
        end else if (in_id) begin
            opcode <= instr[FIELD_OPCODE_MSB:FIELD_OPCODE_LSB];
            func   <= instr[FIELD_FUNC_MSB:FIELD_FUNC_LSB];
            imm    <= instr[FIELD_IMM_MSB:FIELD_IMM_LSB];
            dest   <= dest_sel(instr);
        end else if (wb_commit) begin
            // A dest of r0 still counts: the instruction retired, it just has no visible effect.
            retired <= retired + 8'd1;
        end
    end

    regfile_2r1w #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rstn     (rstn),
        .rd_en    (in_id),
        .ra       (instr[FIELD_RS_MSB:FIELD_RS_LSB]),
        .rb       (instr[FIELD_RT_MSB:FIELD_RT_LSB]),
        .rdata_a  (rsv),
        .rdata_b  (rtv),
        .we       (wb_commit),
        .wa       (dest),
        .wd       (result),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_decode_regfile.sv
// tb/tb_decode_regfile.sv - randomized and directed self-checking bench for decode_regfile
module tb_decode_regfile;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  state;
    logic [31:0] instr;
    logic [7:0]  result;
    logic        instruction_invalid;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [7:0]  rsv;
    logic [7:0]  rtv;
    logic [4:0]  dest;
    logic [7:0]  retired;
    logic [4:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int errors = 0;
    int checks = 0;

    int m_regs [32];
    int m_retired;
    int m_dest;

    always #5 clk = ~clk;

    decode_regfile dut (
        .clk                 (clk),
        .rstn                (rstn),
        .state               (state),
        .instr               (instr),
        .result              (result),
        .instruction_invalid (instruction_invalid),
        .opcode              (opcode),
        .func                (func),
        .imm                 (imm),
        .rsv                 (rsv),
        .rtv                 (rtv),
        .dest                (dest),
        .retired             (retired),
        .dbg_addr            (dbg_addr),
        .dbg_data            (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = a[4:0];
            #1;
            chk($sformatf("%s_r%0d", tag, a), {24'd0, dbg_data}, m_regs[a]);
        end
    endtask

    // ID then one EX cycle; outputs must still hold the values decoded in ID.
    task automatic do_id(input logic [31:0] ins, input string tag);
        int op, rs, rt, rd;
        op = ins >> 26;
        rs = (ins >> 21) & 31;
        rt = (ins >> 16) & 31;
        rd = (ins >> 11) & 31;
        m_dest = (op == 0) ? rd : rt;
        state = 3'd1;
        instr = ins;
        cyc();
        state = 3'd2;
        instr = $urandom;
        cyc();
        chk({tag, "_opcode"}, {26'd0, opcode}, op);
        chk({tag, "_func"},   {26'd0, func}, ins & 32'h3F);
        chk({tag, "_imm"},    {16'd0, imm}, ins & 32'hFFFF);
        chk({tag, "_rsv"},    {24'd0, rsv}, m_regs[rs]);
        chk({tag, "_rtv"},    {24'd0, rtv}, m_regs[rt]);
        chk({tag, "_dest"},   {27'd0, dest}, m_dest);
    endtask

    task automatic do_wb(input logic [7:0] res, input logic inv, input string tag);
        state = 3'd3;
        result = res;
        instruction_invalid = inv;
        cyc();
        state = 3'd0;
        result = $urandom;
        instruction_invalid = $urandom;
        if (!inv) begin
            if (m_dest != 0) m_regs[m_dest] = res;
            m_retired = (m_retired + 1) % 256;
        end
        dbg_addr = m_dest[4:0];
        #1;
        chk({tag, "_wbreg"},   {24'd0, dbg_data}, m_regs[m_dest]);
        chk({tag, "_retired"}, {24'd0, retired}, m_retired);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_retired = 0;
        m_dest = 0;
    endtask

    initial begin
        logic [31:0] ins;
        int start_ret;
        rstn = 1'b0;
        state = 3'd0;
        instr = '0;
        result = '0;
        instruction_invalid = 1'b0;
        dbg_addr = '0;
        model_reset();
        cyc();
        rstn = 1'b1;
        cyc();

        sweep("reset");
        chk("reset_retired", {24'd0, retired}, 0);
        chk("reset_opcode", {26'd0, opcode}, 0);

        do_id(32'h24030005, "addiu_r3");
        do_wb(8'h05, 1'b0, "addiu_r3");
        do_id(32'h240400FD, "addiu_r4");
        do_wb(8'hFD, 1'b0, "addiu_r4");
        do_id(32'h00642821, "addu_r5");
        do_wb(8'h02, 1'b0, "addu_r5");

        do_id(32'h240700AA, "inv_r7");
        do_wb(8'hAA, 1'b1, "inv_r7");
        do_id(32'h24000055, "dest_r0");
        do_wb(8'h55, 1'b0, "dest_r0");

        // Idle/unused state encodings must leave everything alone.
        state = 3'd6;
        result = 8'h77;
        instruction_invalid = 1'b0;
        instr = 32'h24090001;
        cyc();
        state = 3'd0;
        chk("idle_retired", {24'd0, retired}, m_retired);
        sweep("idle");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: ins = {6'h09, 5'($urandom), 5'($urandom), 16'($urandom)};
                1: ins = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, 6'h21};
                2: ins = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, 6'h23};
                default: ins = $urandom;
            endcase
            do_id(ins, $sformatf("rnd%0d", n));
            do_wb(8'($urandom), ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n));
        end
        sweep("after_rnd");

        do_id(32'h240A0000, "wrap_id");
        start_ret = m_retired;
        for (int n = 0; n < 256; n++) begin
            state = 3'd3;
            result = 8'(n);
            instruction_invalid = 1'b0;
            cyc();
            m_regs[10] = n;
            m_retired = (m_retired + 1) % 256;
        end
        state = 3'd0;
        chk("wrap_retired", {24'd0, retired}, start_ret);
        chk("wrap_model", m_retired, start_ret);
        dbg_addr = 5'd10;
        #1;
        chk("wrap_r10", {24'd0, dbg_data}, 8'hFF);

        do_id(32'h240B0033, "midrst_id");
        state = 3'd3;
        result = 8'h33;
        instruction_invalid = 1'b0;
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        state = 3'd0;
        model_reset();
        sweep("midrst");
        chk("midrst_retired", {24'd0, retired}, 0);
        chk("midrst_rsv", {24'd0, rsv}, 0);
        chk("midrst_rtv", {24'd0, rtv}, 0);
        chk("midrst_dest", {27'd0, dest}, 0);
        chk("midrst_imm", {16'd0, imm}, 0);
        chk("midrst_func", {26'd0, func}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
